// File: rtl/line_memory_responder.sv
// Off-chip line memory model answering dcache line requests after a fixed latency.
// One request in flight; aborted requests (enable dropped early) commit nothing.
module line_memory_responder #(
    parameter int unsigned LATENCY     = 10,
    parameter int unsigned DEPTH_LINES = 512,
    parameter int unsigned LINE_BITS   = 256,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 mem_enable_i,
    input  logic                 mem_write_i,
    input  logic [ADDR_W-1:0]    mem_addr_i,
    input  logic [LINE_BITS-1:0] mem_data_i,
    output logic                 mem_ack_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic                 busy_o,
    output logic                 proto_err_o
);
    localparam int unsigned IdxW = $clog2(DEPTH_LINES);

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 wr_q;
    logic [IdxW-1:0]      idx_q;
    logic [LINE_BITS-1:0] wdata_q;
    logic [LINE_BITS-1:0] rdata_q;
    logic                 accept, access;
    logic                 acc_wr;
    logic [IdxW-1:0]      acc_idx;
    logic [LINE_BITS-1:0] acc_data;

    logic [LINE_BITS-1:0] mem_q [DEPTH_LINES];

    // Offset bits and bits above the line index never select anything.
    logic unused_addr;
    assign unused_addr = ^{mem_addr_i[ADDR_W-1:IdxW+5], mem_addr_i[4:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        accept  = 1'b0;
        access  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_enable_i) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_d = StAck;
                        access  = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 8'(LATENCY - 1);
                    end
                end
            end
            StWait: begin
                if (!mem_enable_i) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else if (cnt_q == 8'd1) begin
                    state_d = StAck;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // With single-cycle latency the access happens on the acceptance edge itself,
    // so the values being latched are taken straight from the request.
    always_comb begin
        acc_wr   = accept ? mem_write_i : wr_q;
        acc_idx  = accept ? mem_addr_i[5 +: IdxW] : idx_q;
        acc_data = accept ? mem_data_i : wdata_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (accept) begin
                wr_q    <= mem_write_i;
                idx_q   <= mem_addr_i[5 +: IdxW];
                wdata_q <= mem_data_i;
            end
            if (access && !acc_wr) begin
                rdata_q <= mem_q[acc_idx];
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && access && acc_wr) begin
            mem_q[acc_idx] <= acc_data;
        end
    end

    assign mem_ack_o   = (state_q == StAck);
    assign busy_o      = (state_q == StWait);
    assign proto_err_o = err_q;
    assign mem_data_o  = rdata_q;

endmodule

// File: tb/tb_line_memory_responder.sv
// Bench for line_memory_responder: directed scenarios plus random traffic on a
// LATENCY=10 instance and a LATENCY=1 instance, checked against a line-array model.
module tb_line_memory_responder;
    logic         clk = 1'b0;
    logic         rst;
    logic         en   [2];
    logic         we   [2];
    logic [31:0]  ad   [2];
    logic [255:0] di   [2];
    logic         ack  [2];
    logic         busy [2];
    logic         err  [2];
    logic [255:0] dq   [2];

    logic [255:0] mdl     [2][512];
    bit           vld     [2][512];
    logic [255:0] last_rd [2];
    int unsigned  lat     [2];
    int           n_chk = 0;
    int           n_pass = 0;

    always #5 clk = ~clk;

    line_memory_responder #(.LATENCY(10), .DEPTH_LINES(512), .LINE_BITS(256), .ADDR_W(32)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .mem_enable_i(en[0]), .mem_write_i(we[0]),
        .mem_addr_i(ad[0]), .mem_data_i(di[0]), .mem_ack_o(ack[0]), .mem_data_o(dq[0]),
        .busy_o(busy[0]), .proto_err_o(err[0])
    );

    line_memory_responder #(.LATENCY(1), .DEPTH_LINES(512), .LINE_BITS(256), .ADDR_W(32)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .mem_enable_i(en[1]), .mem_write_i(we[1]),
        .mem_addr_i(ad[1]), .mem_data_i(di[1]), .mem_ack_o(ack[1]), .mem_data_o(dq[1]),
        .busy_o(busy[1]), .proto_err_o(err[1])
    );

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 32) % 512);
    endfunction

    function automatic logic [255:0] rnd_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Counts negedges until ack (bounded); nb counts busy cycles seen before it.
    task automatic wait_ack(input int d, output int n, output int nb);
        n  = 0;
        nb = 0;
        do begin
            @(negedge clk);
            n++;
            if (!ack[d] && busy[d] === 1'b1) nb++;
        end while (ack[d] !== 1'b1 && n < 300);
    endtask

    task automatic req(input int d, input bit wr, input logic [31:0] a, input logic [255:0] data);
        int n, nb, idx;
        idx   = idx_of(a);
        en[d] = 1'b1; we[d] = wr; ad[d] = a; di[d] = data;
        @(posedge clk); #1;
        // Request fields may wander once accepted.
        we[d] = 1'($urandom); ad[d] = $urandom; di[d] = rnd_line();
        wait_ack(d, n, nb);
        chk("latency", n, lat[d]);
        chk("busy_cycles", nb, lat[d] - 1);
        chk("err_in_ack", err[d], 1'b0);
        if (wr) begin
            mdl[d][idx] = data;
            vld[d][idx] = 1'b1;
            chk("wr_keeps_rdata", dq[d], last_rd[d]);
        end else begin
            chk("rdata", dq[d], mdl[d][idx]);
            last_rd[d] = mdl[d][idx];
        end
        @(posedge clk); #1;
        en[d] = 1'b0;
        @(negedge clk);
        chk("ack_width", ack[d], 1'b0);
    endtask

    task automatic abort_req(input logic [31:0] a, input logic [255:0] data, input int k);
        en[0] = 1'b1; we[0] = 1'b1; ad[0] = a; di[0] = data;
        @(posedge clk);
        repeat (k) @(posedge clk);
        #1 en[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_err", err[0], 1'b1);
        chk("abort_noack", ack[0], 1'b0);
        chk("abort_idle", busy[0], 1'b0);
        @(negedge clk);
        chk("err_width", err[0], 1'b0);
        chk("abort_noack2", ack[0], 1'b0);
    endtask

    initial begin
        int n, nb, seen, idx;
        bit wr;
        logic [31:0] a;
        logic [255:0] c_line;
        lat = '{10, 1};
        last_rd = '{256'd0, 256'd0};
        for (int d = 0; d < 2; d++) begin
            en[d] = 1'b1; we[d] = 1'b1; ad[d] = 32'h0000_0100; di[d] = '1;
        end
        rst = 1'b1;

        // Reset held with a request pending.
        repeat (2) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                chk("rst_ack", ack[d], 1'b0);
                chk("rst_data", dq[d], 256'd0);
                chk("rst_busy", busy[d], 1'b0);
                chk("rst_err", err[d], 1'b0);
            end
        end
        rst = 1'b0;
        en[0] = 1'b0; en[1] = 1'b0;
        @(negedge clk);

        // Write then read back.
        req(0, 1'b1, 32'h0000_0400, {8{32'hDEADBEEF}});
        req(0, 1'b0, 32'h0000_0400, 256'd0);
        chk("read_deadbeef", dq[0], {8{32'hDEADBEEF}});
        req(0, 1'b1, 32'h0000_0020, {8{32'h1234_5678}});

        // Back-to-back: enable held across the ack with a new read request.
        en[0] = 1'b1; we[0] = 1'b1; ad[0] = 32'h0000_0400; di[0] = {8{32'hCAFE_F00D}};
        @(posedge clk); #1;
        wait_ack(0, n, nb);
        chk("b2b_first_lat", n, lat[0]);
        mdl[0][idx_of(32'h400)] = {8{32'hCAFE_F00D}};
        we[0] = 1'b0; ad[0] = 32'h0000_0020;
        wait_ack(0, n, nb);
        chk("b2b_spacing", n, lat[0] + 1);
        chk("b2b_rdata", dq[0], mdl[0][idx_of(32'h20)]);
        last_rd[0] = mdl[0][idx_of(32'h20)];
        @(posedge clk); #1 en[0] = 1'b0;
        @(negedge clk);
        req(0, 1'b0, 32'h0000_0400, 256'd0);
        chk("b2b_first_kept", dq[0], {8{32'hCAFE_F00D}});

        // Aborted write must not commit.
        req(0, 1'b1, 32'h0000_0040, {8{32'hA5A5_0040}});
        abort_req(32'h0000_0040, {8{32'h5A5A_FFFF}}, 4);
        req(0, 1'b0, 32'h0000_0040, 256'd0);
        chk("abort_kept", dq[0], {8{32'hA5A5_0040}});

        // Reset in the middle of a write.
        c_line = rnd_line();
        req(0, 1'b1, 32'h0000_0080, c_line);
        en[0] = 1'b1; we[0] = 1'b1; ad[0] = 32'h0000_0080; di[0] = rnd_line();
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1; en[0] = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        last_rd = '{256'd0, 256'd0};
        @(negedge clk);
        chk("midrst_busy", busy[0], 1'b0);
        chk("midrst_data", dq[0], 256'd0);
        seen = 0;
        repeat (lat[0] + 3) begin
            @(negedge clk);
            if (ack[0] === 1'b1) seen++;
        end
        chk("midrst_no_ack", seen, 0);
        req(0, 1'b0, 32'h0000_0080, 256'd0);
        chk("midrst_kept", dq[0], c_line);

        // Wrap and alignment on the single-cycle instance.
        req(1, 1'b1, 32'h0000_4000, {8{32'h0BAD_CAFE}});
        req(1, 1'b0, 32'h0000_001F, 256'd0);
        chk("wrap_read", dq[1], {8{32'h0BAD_CAFE}});

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            idx = $urandom_range(0, 15);
            a   = ($urandom & 32'hFFFF_C000) | (idx << 5) | $urandom_range(0, 31);
            wr  = !vld[0][idx] || ($urandom_range(0, 1) == 1);
            if (wr && $urandom_range(0, 7) == 0) abort_req(a, rnd_line(), $urandom_range(0, 8));
            else req(0, wr, a, rnd_line());
        end
        for (int i = 0; i < 20; i++) begin
            idx = $urandom_range(0, 7);
            a   = ($urandom & 32'hFFFF_C000) | (idx << 5) | $urandom_range(0, 31);
            wr  = !vld[1][idx] || ($urandom_range(0, 1) == 1);
            req(1, wr, a, rnd_line());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
